// File: rtl/serial_adder_ctrl.sv
// -----------------------------------------------------------------------------
// serial_adder_ctrl
//
// Bit-serial adder controller. A single 1-bit full-adder cell is reused over
// WIDTH clock cycles to add two WIDTH-bit operands, least significant bit
// first. Operands are captured into shift registers on an accepted start.
// The carry is held in a flop between bits. Sum bits are shifted in at the
// top of the result register, so after WIDTH bits the LSB sits at bit 0.
//
// Ports:
//   clk    in   1      clock, rising edge
//   rst    in   1      asynchronous active-high reset
//   start  in   1      request, sampled only while ready=1
//   ready  out  1      high in IDLE only
//   a      in   WIDTH  operand A, captured on the accepted start
//   b      in   WIDTH  operand B, captured on the accepted start
//   cin    in   1      carry-in, captured on the accepted start
//   sub    in   1      (only with SERIAL_ADDER_SUB_EN) 1 = compute a-b
//   busy   out  1      high while bits are being processed
//   done   out  1      high while the result is valid
//   ack    in   1      consumer acknowledge, sampled only while done=1
//   sum    out  WIDTH  result, valid while done=1
//   cout   out  1      final carry-out (no-borrow flag when subtracting)
//
// Optional build macro: SERIAL_ADDER_SUB_EN adds the sub port. Subtraction
// is a + ~b + 1.
// -----------------------------------------------------------------------------
module serial_adder_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  input  logic             ack,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           state_q;
  logic             ready_q;
  logic             busy_q;
  logic             done_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] a_sh_q;
  logic [WIDTH-1:0] b_sh_q;
  logic [WIDTH-1:0] s_sh_q;
  logic             c_q;

  // Full-adder cell outputs for the bit currently at the bottom of the shifters.
  logic             sum_bit_d;
  logic             carry_d;

  // Values loaded into the B shifter and carry flop on an accepted start.
  logic [WIDTH-1:0] b_load_d;
  logic             c_load_d;

  always_comb begin
    sum_bit_d = a_sh_q[0] ^ b_sh_q[0] ^ c_q;
    carry_d   = (a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & c_q) | (b_sh_q[0] & c_q);
  end

`ifdef SERIAL_ADDER_SUB_EN
  // Two's-complement subtraction: invert B and force the carry-in to 1.
  always_comb begin
    b_load_d = sub ? ~b : b;
    c_load_d = sub ? 1'b1 : cin;
  end
`else
  always_comb begin
    b_load_d = b;
    c_load_d = cin;
  end
`endif

  // Control and datapath live in one block. ready/busy/done are flops that
  // track the state one-hot, so the handshake outputs never glitch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      s_sh_q  <= '0;
      c_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            a_sh_q  <= a;
            b_sh_q  <= b_load_d;
            c_q     <= c_load_d;
            cnt_q   <= '0;
            state_q <= ST_RUN;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        ST_RUN: begin
          s_sh_q <= {sum_bit_d, s_sh_q[WIDTH-1:1]};
          a_sh_q <= {1'b0, a_sh_q[WIDTH-1:1]};
          b_sh_q <= {1'b0, b_sh_q[WIDTH-1:1]};
          c_q    <= carry_d;
          cnt_q  <= cnt_q + CNT_W'(1);
          if (cnt_q == LAST_CNT) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        ST_DONE: begin
          // Result registers are left untouched so sum/cout persist into IDLE.
          if (ack) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b0;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign ready = ready_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign sum   = s_sh_q;
  assign cout  = c_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Testbench for serial_adder_ctrl (WIDTH=8). Expected results come from plain
// integer arithmetic on the operands. They do not come from the DUT.
module tb_serial_adder_ctrl;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst;
  logic             start;
  logic             ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef SERIAL_ADDER_SUB_EN
  logic             sub;
`endif
  logic             busy;
  logic             done;
  logic             ack;
  logic [WIDTH-1:0] sum;
  logic             cout;

  int checks;
  int errors;
  int cyc;

  serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .ready (ready),
    .a     (a),
    .b     (b),
    .cin   (cin),
`ifdef SERIAL_ADDER_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .ack   (ack),
    .sum   (sum),
    .cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one request from IDLE and waits for done. It scrambles the operand
  // inputs after acceptance. It reports the edge count from acceptance to done,
  // with a bound of 40 edges.
  task automatic run_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                        input logic tc, output int lat,
                        output logic [WIDTH-1:0] rs, output logic rc);
    a = ta; b = tb; cin = tc; start = 1'b1;
    tick();
    start = 1'b0;
    a = WIDTH'($urandom); b = WIDTH'($urandom); cin = 1'($urandom);
    lat = 0;
    while (done !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    rs = sum;
    rc = cout;
    $display("op a=%02h b=%02h cin=%0d -> sum=%02h cout=%0d latency=%0d", ta, tb, tc, rs, rc, lat);
  endtask

  task automatic test_reset();
    #2;
    checks++; if ({ready, busy, done} !== 3'b100) begin errors++;
      $display("FAIL reset_flags got=%b exp=100", {ready, busy, done}); end
    checks++; if ({cout, sum} !== 9'h000) begin errors++;
      $display("FAIL reset_result got=%h exp=000", {cout, sum}); end
    start = 1'b1;
    tick(); tick();
    start = 1'b0;
    rst = 1'b0;
    tick();
    checks++; if ({ready, busy, done} !== 3'b100) begin errors++;
      $display("FAIL post_reset_idle got=%b exp=100", {ready, busy, done}); end
  endtask

  task automatic test_basic();
    int lat; logic [WIDTH-1:0] rs; logic rc;
    run_op(8'h5A, 8'h3C, 1'b0, lat, rs, rc);
    checks++; if (lat != WIDTH) begin errors++;
      $display("FAIL basic_latency got=%0d exp=%0d", lat, WIDTH); end
    checks++; if ({rc, rs} !== 9'h096) begin errors++;
      $display("FAIL basic_sum got=%h exp=096", {rc, rs}); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if ({done, cout, sum} !== {1'b1, 9'h096}) begin errors++;
        $display("FAIL basic_hold got=%h exp=%h", {done, cout, sum}, {1'b1, 9'h096}); end
    end
    ack = 1'b1; tick(); ack = 1'b0;
    checks++; if ({ready, busy, done, cout, sum} !== {3'b100, 9'h096}) begin errors++;
      $display("FAIL basic_after_ack got=%h exp=%h", {ready, busy, done, cout, sum}, {3'b100, 9'h096}); end

    run_op(8'hFF, 8'h01, 1'b0, lat, rs, rc);
    checks++; if ({rc, rs} !== 9'h100) begin errors++;
      $display("FAIL wrap_ff_01 got=%h exp=100", {rc, rs}); end
    ack = 1'b1; tick(); ack = 1'b0;
    run_op(8'hFF, 8'h00, 1'b1, lat, rs, rc);
    checks++; if ({rc, rs} !== 9'h100) begin errors++;
      $display("FAIL wrap_ff_cin got=%h exp=100", {rc, rs}); end
    ack = 1'b1; tick(); ack = 1'b0;
  endtask

  task automatic test_start_ignored();
    int lat;
    a = 8'h11; b = 8'h22; cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    a = 8'hAA; start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if ({ready, busy} !== 2'b01) begin errors++;
      $display("FAIL run_flags got=%b exp=01", {ready, busy}); end
    lat = 4;
    while (done !== 1'b1 && lat < 40) begin tick(); lat++; end
    $display("op a=11 b=22 cin=0 -> sum=%02h cout=%0d latency=%0d", sum, cout, lat);
    checks++; if (lat != WIDTH) begin errors++;
      $display("FAIL ignore_latency got=%0d exp=%0d", lat, WIDTH); end
    checks++; if ({cout, sum} !== 9'h033) begin errors++;
      $display("FAIL ignore_start_sum got=%h exp=033", {cout, sum}); end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if ({done, cout, sum} !== {1'b1, 9'h033}) begin errors++;
        $display("FAIL done_stable cycle=%0d got=%h exp=%h", i, {done, cout, sum}, {1'b1, 9'h033}); end
    end
    ack = 1'b1; tick(); ack = 1'b0;
    checks++; if ({ready, busy, done} !== 3'b100) begin errors++;
      $display("FAIL ack_to_idle got=%b exp=100", {ready, busy, done}); end
    // An ack that arrives in IDLE must not disturb the state.
    ack = 1'b1; tick(); ack = 1'b0;
    checks++; if ({ready, busy, done} !== 3'b100) begin errors++;
      $display("FAIL ack_in_idle got=%b exp=100", {ready, busy, done}); end
  endtask

  task automatic test_async_reset();
    int lat; logic [WIDTH-1:0] rs; logic rc;
    a = 8'hF0; b = 8'h0F; cin = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick(); tick();
    checks++; if (busy !== 1'b1) begin errors++;
      $display("FAIL mid_run_busy got=%b exp=1", busy); end
    #2 rst = 1'b1;
    #1;
    checks++; if ({ready, busy, done, cout, sum} !== {3'b100, 9'h000}) begin errors++;
      $display("FAIL async_reset got=%h exp=%h", {ready, busy, done, cout, sum}, {3'b100, 9'h000}); end
    tick(); tick();
    rst = 1'b0;
    tick();
    checks++; if (done !== 1'b0) begin errors++;
      $display("FAIL no_done_after_reset got=%b exp=0", done); end
    run_op(8'h01, 8'h01, 1'b0, lat, rs, rc);
    checks++; if ({rc, rs} !== 9'h002) begin errors++;
      $display("FAIL after_reset_sum got=%h exp=002", {rc, rs}); end
    ack = 1'b1; tick(); ack = 1'b0;
  endtask

  task automatic test_back_to_back();
    int t0, t1, w;
    ack = 1'b1;
    a = 8'd1; b = 8'd2; cin = 1'b0; start = 1'b1;
    tick();
    t0 = cyc;
    a = 8'd3; b = 8'd4;
    w = 0;
    while (done !== 1'b1 && w < 40) begin tick(); w++; end
    $display("op a=01 b=02 cin=0 -> sum=%02h cout=%0d", sum, cout);
    checks++; if ({cout, sum} !== 9'h003) begin errors++;
      $display("FAIL b2b_first got=%h exp=003", {cout, sum}); end
    tick();
    checks++; if ({ready, busy, done} !== 3'b100) begin errors++;
      $display("FAIL b2b_start_in_ack_cycle got=%b exp=100", {ready, busy, done}); end
    tick();
    t1 = cyc;
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++;
      $display("FAIL b2b_second_accept got=%b exp=1", busy); end
    checks++; if (t1 - t0 != WIDTH + 2) begin errors++;
      $display("FAIL b2b_interval got=%0d exp=%0d", t1 - t0, WIDTH + 2); end
    w = 0;
    while (done !== 1'b1 && w < 40) begin tick(); w++; end
    $display("op a=03 b=04 cin=0 -> sum=%02h cout=%0d", sum, cout);
    checks++; if ({cout, sum} !== 9'h007) begin errors++;
      $display("FAIL b2b_second got=%h exp=007", {cout, sum}); end
    tick();
    ack = 1'b0;
  endtask

  task automatic test_random();
    int lat; logic [WIDTH-1:0] rs; logic rc;
    logic [WIDTH-1:0] ra, rb; logic rcin;
    int expv;
    for (int n = 0; n < 20; n++) begin
      ra = WIDTH'($urandom); rb = WIDTH'($urandom); rcin = 1'($urandom);
      expv = int'(ra) + int'(rb) + int'(rcin);
      run_op(ra, rb, rcin, lat, rs, rc);
      checks++; if (lat != WIDTH || {rc, rs} !== 9'(expv)) begin errors++;
        $display("FAIL random_add n=%0d got=%h lat=%0d exp=%h lat=%0d", n, {rc, rs}, lat, 9'(expv), WIDTH); end
      for (int d = $urandom_range(0, 3); d > 0; d--) tick();
      ack = 1'b1; tick(); ack = 1'b0;
    end
  endtask

`ifdef SERIAL_ADDER_SUB_EN
  task automatic test_sub();
    int lat; logic [WIDTH-1:0] rs; logic rc;
    logic [WIDTH-1:0] ra, rb;
    sub = 1'b1;
    run_op(8'h10, 8'h01, 1'b0, lat, rs, rc);
    checks++; if ({rc, rs} !== 9'h10F) begin errors++;
      $display("FAIL sub_10_01 got=%h exp=10F", {rc, rs}); end
    ack = 1'b1; tick(); ack = 1'b0;
    run_op(8'h01, 8'h02, 1'b1, lat, rs, rc);
    checks++; if ({rc, rs} !== 9'h0FF) begin errors++;
      $display("FAIL sub_01_02 got=%h exp=0FF", {rc, rs}); end
    ack = 1'b1; tick(); ack = 1'b0;
    for (int n = 0; n < 10; n++) begin
      ra = WIDTH'($urandom); rb = WIDTH'($urandom);
      run_op(ra, rb, 1'($urandom), lat, rs, rc);
      checks++; if (rs !== WIDTH'(int'(ra) - int'(rb)) || rc !== (ra >= rb)) begin errors++;
        $display("FAIL random_sub n=%0d got=%h exp=%h", n, {rc, rs}, {(ra >= rb), WIDTH'(int'(ra) - int'(rb))}); end
      ack = 1'b1; tick(); ack = 1'b0;
    end
    sub = 1'b0;
  endtask
`endif

  initial begin
    checks = 0; errors = 0;
    rst = 1'b1; start = 1'b0; ack = 1'b0;
    a = '0; b = '0; cin = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
    sub = 1'b0;
`endif
    test_reset();
    test_basic();
    test_start_ignored();
    test_async_reset();
    test_back_to_back();
    test_random();
`ifdef SERIAL_ADDER_SUB_EN
    test_sub();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
Bit-serial adder controller. It time-multiplexes one 1-bit full-adder cell over WIDTH cycles to add two WIDTH-bit operands, LSB first.
- Holds operand shift registers, the carry flop and the result shift register.
- Sequences the cell with an IDLE/RUN/DONE FSM.
- Exposes a start/ready request side and a done/ack result side.
- Used where area matters more than latency, e.g. accumulators and checksum paths.

Parameters:
WIDTH, 8, operand and result width in bits; legal range 2..32.
CNT_W, $clog2(WIDTH)+1, bit-counter width; derived, not to be overridden.

Ports:
clk  input  1  single clock, rising edge.
rst  input  1  asynchronous, active-high reset.
start  input  1  request; sampled only when ready=1.
ready  output  1  high in IDLE only.
a  input  WIDTH  operand A; captured on the accepted start.
b  input  WIDTH  operand B; captured on the accepted start.
cin  input  1  carry-in; captured on the accepted start.
busy  output  1  high in RUN.
done  output  1  high in DONE; result valid.
ack  input  1  consumer acknowledge; sampled only in DONE.
sum  output  WIDTH  result; valid while done=1.
cout  output  1  final carry-out; valid while done=1.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, ready=1, busy=0, done=0, sum=0, cout=0.
  - Counter, shift registers and carry flop are all cleared.
- Cell function, used identically for every bit:
  - s = x^y^c
  - co = x&y | x&c | y&c
- IDLE:
  - ready=1.
  - On an edge with start=1: load A_sh<=a, B_sh<=b, c<=cin, cnt<=0; go to RUN.
- RUN, one bit per edge:
  - x=A_sh[0], y=B_sh[0].
  - S_sh <= {s, S_sh[WIDTH-1:1]}.
  - A_sh and B_sh shift right by 1.
  - c <= co, cnt <= cnt+1.
  - On the edge processing cnt==WIDTH-1: go to DONE.
- DONE:
  - sum=S_sh, cout=c, both held stable.
  - On an edge with ack=1: go to IDLE and set done=0.
  - sum and cout keep their last value until the next load.
- Latency and throughput:
  - done rises exactly WIDTH edges after the acceptance edge.
  - Minimum issue interval is WIDTH+2 cycles when ack is tied high.
- Boundary conditions:
  - start while busy or done: ignored; operands are not recaptured. ready=0 signals this.
  - ack outside DONE: ignored.
  - start and ack in the same DONE cycle: ack is honoured and start ignored. The next start is accepted one cycle later in IDLE.
  - a, b and cin may change freely after acceptance with no effect.
  - Carry wrap: overflow appears only on cout; sum is modulo 2^WIDTH.
  - rst asserted mid-RUN or in DONE: immediate return to the reset state. The partial result is discarded and no done is issued.
- States are exclusive; ready, busy and done are one-hot, driven straight from state flops (registered, glitch-free).

Optional Feature:
SERIAL_ADDER_SUB_EN
- Defined:
  - Adds input port sub (1 bit), captured on the accepted start.
  - When sub=1: B_sh loads ~b and c loads 1 (cin ignored), giving sum = a-b mod 2^WIDTH.
  - cout=1 means no borrow (a>=b).
  - sub=0 behaves as plain add.
- Undefined: no sub port; add-only datapath; no extra logic.

Test Plan:
WIDTH=8 unless stated.
1. a=0x5A, b=0x3C, cin=0, start one cycle -> done exactly 8 edges later, sum=0x96, cout=0; held until ack.
2. a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Then a=0xFF, b=0x00, cin=1 -> sum=0x00, cout=1.
3. start with a=0x11, b=0x22; pulse start at RUN cycle 3 with a=0xAA -> ignored, sum=0x33. Hold ack=0 for 5 cycles in DONE -> done, sum and cout stable. ack=1 -> IDLE next edge, ready=1.
4. Assert rst at RUN cycle 4 -> busy=0, done=0, ready=1, sum=0 immediately (asynchronous). New op 0x01+0x01 after release -> sum=0x02.
5. ack tied high, back-to-back starts -> results 0x03 and 0x07 for inputs (1,2) and (3,4); issue interval 10 cycles. A start in the ack cycle is ignored.
6. With SERIAL_ADDER_SUB_EN: a=0x10, b=0x01, sub=1 -> sum=0x0F, cout=1. a=0x01, b=0x02, sub=1 -> sum=0xFF, cout=0.
